// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serializer_pkg
//  Purpose  : Shared state encodings and index-width helper for the
//             parallel-to-serial front end.
//  Revision : 1.0  initial release
// ============================================================================
package serializer_pkg;

  // Shifter FSM encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bit-index width for a word of the given width (never below one bit)
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serializer_if
//  Purpose  : Word-in / bit-out bundle of the serializer. The master side
//             offers words and observes the serial stream; the slave side is
//             the serializer itself.
//  Revision : 1.0  initial release
// ============================================================================
interface bit_serializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, last, busy, words_sent
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, last, busy, words_sent
  );
endinterface
`default_nettype wire

// File: rtl/ser_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ser_hold_buf
//  Purpose  : One-entry valid/ready holding buffer. Ready depends only on the
//             stored flag and reset, so there is no path from in_valid.
//  Revision : 1.0  initial release
// ============================================================================
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_take
);

  logic             full;
  logic [WIDTH-1:0] data;
  logic             write;

  assign in_ready  = rst & ~full;
  assign write     = in_valid & in_ready;
  assign out_data  = data;
  assign out_valid = full;

  // Occupancy: a write fills the slot, a take without a write empties it
  always_ff @(posedge clk) begin
    if (!rst) full <= 1'b0;
    else      full <= write | (full & ~out_take);
  end

  // Payload is captured only on an accepting edge
  always_ff @(posedge clk) begin
    if (write) data <= in_data;
  end

endmodule
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serializer
//  Purpose  : Parallel-to-serial front end. Words arrive over valid/ready and
//             leave one bit per clock on sout; a one-entry hold buffer lets
//             words stream back-to-back with no idle bit in between.
//  Revision : 1.0  initial release
// ============================================================================
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_serializer_if.slave       bus
);

  localparam int             IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  // Shifter state
  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] word;

  // Registered outputs
  logic             sout_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic [CNT_W-1:0] count;

  // Hold buffer connections
  logic             hold_in_ready;
  logic             hold_in_valid;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             hold_take;
  logic             hold_full_next;

  // Load decision
  logic             accept;
  logic             at_end;
  logic             bypass;

  // Next shifter state
  logic [0:0]       next_state;
  logic [IDX_W-1:0] next_idx;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] ordered;
  logic             next_bit;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (bus.din),
    .in_valid  (hold_in_valid),
    .in_ready  (hold_in_ready),
    .out_data  (hold_data),
    .out_valid (hold_full),
    .out_take  (hold_take)
  );

  assign accept         = bus.din_valid & hold_in_ready;
  // The shifter can take a new word when empty or on its final bit
  assign at_end         = (state == ST_IDLE) | (idx == IDX_LAST);
  assign hold_take      = at_end & hold_full;
  assign bypass         = at_end & ~hold_full & accept;
  assign hold_in_valid  = accept & ~bypass;
  assign hold_full_next = hold_in_valid | (hold_full & ~hold_take);

  // Next shifter contents: drain hold first, then bypass, else keep shifting
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_word  = word;
    if (hold_take) begin
      next_state = ST_SHIFT;
      next_idx   = '0;
      next_word  = hold_data;
    end else if (bypass) begin
      next_state = ST_SHIFT;
      next_idx   = '0;
      next_word  = bus.din;
    end else if (state == ST_SHIFT) begin
      if (idx == IDX_LAST) begin
        next_state = ST_IDLE;
        next_idx   = '0;
      end else begin
        next_idx   = idx + IDX_W'(1);
      end
    end
  end

  // Bit order is fixed at elaboration: reverse the word for MSB-first so a
  // rising index always walks the transmit order
  if (MSB_FIRST != 0) begin : g_msb_first
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign ordered[i] = next_word[WIDTH-1-i];
    end
  end else begin : g_lsb_first
    assign ordered = next_word;
  end

  assign next_bit = ordered[next_idx];

  // Shifter FSM registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      word  <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      word  <= next_word;
    end
  end

  // Output flops, computed from the next state so every output is registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      sout_q  <= IDLE_BIT;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sout_q  <= (next_state == ST_SHIFT) ? next_bit : IDLE_BIT;
      valid_q <= (next_state == ST_SHIFT);
      last_q  <= (next_state == ST_SHIFT) && (next_idx == IDX_LAST);
      busy_q  <= (next_state == ST_SHIFT) | hold_full_next;
    end
  end

  // Completed-word counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (!rst)        count <= '0;
    else if (last_q) count <= count + CNT_W'(1);
  end

  assign bus.din_ready  = hold_in_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = valid_q;
  assign bus.last       = last_q;
  assign bus.busy       = busy_q;
  assign bus.words_sent = count;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serializer
//  Purpose  : Self-checking bench. Two serializers (MSB-first/16-bit counter
//             and LSB-first/idle-high/2-bit counter) share one input stream
//             and are compared against a word-queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8), .CNT_W(16)) bm ();
  bit_serializer_if #(.WIDTH(8), .CNT_W(2))  bl ();

  assign bm.din       = din;
  assign bm.din_valid = din_valid;
  assign bl.din       = din;
  assign bl.din_valid = din_valid;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(16)) dut_m (
    .clk (clk), .rst (rst), .bus (bm)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1), .CNT_W(2)) dut_l (
    .clk (clk), .rst (rst), .bus (bl)
  );

  // Reference model: words accepted but not yet fully sent, head word is on
  // the wire when active, pos is the transmit position within it.
  logic [7:0] mq[$];
  bit         active = 1'b0;
  int         pos    = 0;
  int         sent   = 0;
  int         tests  = 0;
  int         fails  = 0;

  function automatic bit e_ready();
    return (rst === 1'b1) && ((mq.size() - int'(active)) == 0);
  endfunction
  function automatic bit e_sout_m();
    logic [7:0] w;
    if (!active) return 1'b0;
    w = mq[0];
    return w[7-pos];
  endfunction
  function automatic bit e_sout_l();
    logic [7:0] w;
    if (!active) return 1'b1;
    w = mq[0];
    return w[pos];
  endfunction
  function automatic bit e_last();
    return active && (pos == 7);
  endfunction
  function automatic bit e_busy();
    return mq.size() != 0;
  endfunction

  // Advance one clock and apply the same edge to the model
  task automatic step();
    bit acc;
    @(posedge clk);
    acc = (din_valid === 1'b1) && e_ready();
    if (rst !== 1'b1) begin
      mq.delete();
      active = 1'b0;
      pos    = 0;
      sent   = 0;
    end else if (active) begin
      if (pos == 7) begin
        void'(mq.pop_front());
        sent++;
        pos = 0;
        if (acc) mq.push_back(din);
        active = (mq.size() != 0);
      end else begin
        pos++;
        if (acc) mq.push_back(din);
      end
    end else if (acc) begin
      mq.push_back(din);
      active = 1'b1;
      pos    = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; din_valid = 1'b0; din = '0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; din_valid = 1'b1; din = 8'hA5;
    step(); step();
    #1;
    tests++;
    if ({bm.sout, bm.sout_valid, bm.last, bm.busy, bm.din_ready} !== 5'b00000) begin
      fails++; $display("FAIL reset_m outs got=%b exp=00000", {bm.sout, bm.sout_valid, bm.last, bm.busy, bm.din_ready});
    end
    tests++;
    if ({bl.sout, bl.sout_valid, bl.busy, bl.din_ready} !== 4'b1000) begin
      fails++; $display("FAIL reset_l outs got=%b exp=1000", {bl.sout, bl.sout_valid, bl.busy, bl.din_ready});
    end
    tests++;
    if (bm.words_sent !== 16'd0) begin
      fails++; $display("FAIL reset_count got=%0d exp=0", bm.words_sent);
    end
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (bm.din_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready got=%b exp=1", bm.din_ready);
    end
    step();
  endtask

  task automatic test_single();
    logic [7:0] pat;
    do_reset();
    din = 8'hE0; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = 8'h3C;
    pat = 8'hE0;
    for (int c = 0; c < 10; c++) begin
      #1;
      tests++;
      if ({bm.sout, bm.sout_valid, bm.last} !== {(c < 8) ? pat[7-c] : 1'b0, c < 8, c == 7}) begin
        fails++; $display("FAIL single_m c=%0d got=%b exp=%b", c, {bm.sout, bm.sout_valid, bm.last},
                          {(c < 8) ? pat[7-c] : 1'b0, c < 8, c == 7});
      end
      tests++;
      if ({bl.sout, bl.sout_valid, bl.last, bl.busy} !== {e_sout_l(), active, e_last(), e_busy()}) begin
        fails++; $display("FAIL single_l c=%0d got=%b exp=%b", c, {bl.sout, bl.sout_valid, bl.last, bl.busy},
                          {e_sout_l(), active, e_last(), e_busy()});
      end
      step();
    end
    tests++;
    if (bm.words_sent !== 16'd1) begin
      fails++; $display("FAIL single_count got=%0d exp=1", bm.words_sent);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    int lasts;
    do_reset();
    din = 8'hFF; din_valid = 1'b1;
    step();
    din = 8'h0F;
    #1;
    tests++;
    if (bm.din_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_ready_before got=%b exp=1", bm.din_ready);
    end
    step();
    din_valid = 1'b0;
    nvalid = 1; lasts = 0;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (bm.sout_valid === 1'b1 && c < 15) nvalid++;
      if (bm.last === 1'b1) lasts++;
      tests++;
      if ({bm.sout, bm.sout_valid, bm.last, bm.busy, bm.din_ready} !==
          {e_sout_m(), active, e_last(), e_busy(), e_ready()}) begin
        fails++; $display("FAIL b2b_m c=%0d got=%b exp=%b", c, {bm.sout, bm.sout_valid, bm.last, bm.busy, bm.din_ready},
                          {e_sout_m(), active, e_last(), e_busy(), e_ready()});
      end
      tests++;
      if ({bl.sout, bl.sout_valid, bl.last, bl.din_ready} !== {e_sout_l(), active, e_last(), e_ready()}) begin
        fails++; $display("FAIL b2b_l c=%0d got=%b exp=%b", c, {bl.sout, bl.sout_valid, bl.last, bl.din_ready},
                          {e_sout_l(), active, e_last(), e_ready()});
      end
      step();
    end
    tests++;
    if (nvalid !== 16 || lasts !== 2 || bm.words_sent !== 16'd2) begin
      fails++; $display("FAIL b2b_summary got=valid%0d/last%0d/cnt%0d exp=valid16/last2/cnt2", nvalid, lasts, bm.words_sent);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [3];
    int         k;
    bit         acc;
    words[0] = 8'h96; words[1] = 8'h3A; words[2] = 8'hC5;
    do_reset();
    k = 0;
    for (int c = 0; c < 32; c++) begin
      din_valid = (k < 3);
      din       = (k < 3) ? words[k] : 8'h00;
      #1;
      tests++;
      if ({bm.sout, bm.sout_valid, bm.last, bm.busy, bm.din_ready, bm.words_sent} !==
          {e_sout_m(), active, e_last(), e_busy(), e_ready(), 16'(sent)}) begin
        fails++; $display("FAIL bp_m c=%0d got=%b exp=%b", c,
                          {bm.sout, bm.sout_valid, bm.last, bm.busy, bm.din_ready, bm.words_sent},
                          {e_sout_m(), active, e_last(), e_busy(), e_ready(), 16'(sent)});
      end
      tests++;
      if ({bl.sout, bl.sout_valid, bl.last, bl.din_ready} !== {e_sout_l(), active, e_last(), e_ready()}) begin
        fails++; $display("FAIL bp_l c=%0d got=%b exp=%b", c, {bl.sout, bl.sout_valid, bl.last, bl.din_ready},
                          {e_sout_l(), active, e_last(), e_ready()});
      end
      acc = din_valid && e_ready();
      step();
      if (acc) k++;
    end
    tests++;
    if (bm.words_sent !== 16'd3 || k !== 3) begin
      fails++; $display("FAIL bp_count got=%0d accepted=%0d exp=3", bm.words_sent, k);
    end
  endtask

  task automatic test_lsb();
    do_reset();
    din = 8'h01; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      tests++;
      if ({bl.sout, bl.sout_valid} !== {c == 0, 1'b1}) begin
        fails++; $display("FAIL lsb c=%0d got=%b exp=%b", c, {bl.sout, bl.sout_valid}, {c == 0, 1'b1});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    din = 8'hAA; din_valid = 1'b1;
    step();
    din = 8'h55;
    step();
    din_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    step();
    #1;
    tests++;
    if ({bm.sout_valid, bm.busy, bm.din_ready, bm.words_sent, bl.sout} !== {3'b000, 16'd0, 1'b1}) begin
      fails++; $display("FAIL rstmid_state got=%b exp=%b", {bm.sout_valid, bm.busy, bm.din_ready, bm.words_sent, bl.sout},
                        {3'b000, 16'd0, 1'b1});
    end
    rst = 1'b1;
    step();
    din = 8'h81; din_valid = 1'b1;
    #1;
    tests++;
    if ({bm.sout_valid, bm.busy, bm.din_ready} !== 3'b001) begin
      fails++; $display("FAIL rstmid_release got=%b exp=001", {bm.sout_valid, bm.busy, bm.din_ready});
    end
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      tests++;
      if ({bm.sout, bm.sout_valid, bm.last, bl.sout, bm.words_sent} !==
          {e_sout_m(), active, e_last(), e_sout_l(), 16'(sent)}) begin
        fails++; $display("FAIL rstmid_word c=%0d got=%b exp=%b", c, {bm.sout, bm.sout_valid, bm.last, bl.sout, bm.words_sent},
                          {e_sout_m(), active, e_last(), e_sout_l(), 16'(sent)});
      end
      step();
    end
    tests++;
    if (bm.words_sent !== 16'd1) begin
      fails++; $display("FAIL rstmid_count got=%0d exp=1", bm.words_sent);
    end
  endtask

  task automatic test_wrap();
    int exp_seq [5];
    int k;
    int prev;
    exp_seq = '{1, 2, 3, 0, 1};
    do_reset();
    k = 0;
    prev = sent;
    for (int c = 0; c < 60 && k < 5; c++) begin
      din_valid = 1'b1;
      din = 8'($urandom);
      step();
      if (sent != prev) begin
        prev = sent;
        #1;
        tests++;
        if (bl.words_sent !== 2'(exp_seq[k])) begin
          fails++; $display("FAIL wrap k=%0d got=%0d exp=%0d", k, bl.words_sent, exp_seq[k]);
        end
        k++;
      end
    end
    din_valid = 1'b0;
    tests++;
    if (k !== 5) begin
      fails++; $display("FAIL wrap_timeout got=%0d words exp=5", k);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      din_valid = ($urandom_range(0, 2) != 0);
      din       = 8'($urandom);
      rst       = ($urandom_range(0, 79) != 0);
      #1;
      tests++;
      if ({bm.sout, bm.sout_valid, bm.last, bm.busy, bm.din_ready, bm.words_sent} !==
          {e_sout_m(), active, e_last(), e_busy(), e_ready(), 16'(sent)}) begin
        fails++; $display("FAIL rand_m c=%0d got=%b exp=%b", c,
                          {bm.sout, bm.sout_valid, bm.last, bm.busy, bm.din_ready, bm.words_sent},
                          {e_sout_m(), active, e_last(), e_busy(), e_ready(), 16'(sent)});
      end
      tests++;
      if ({bl.sout, bl.sout_valid, bl.last, bl.busy, bl.din_ready, bl.words_sent} !==
          {e_sout_l(), active, e_last(), e_busy(), e_ready(), 2'(sent)}) begin
        fails++; $display("FAIL rand_l c=%0d got=%b exp=%b", c,
                          {bl.sout, bl.sout_valid, bl.last, bl.busy, bl.din_ready, bl.words_sent},
                          {e_sout_l(), active, e_last(), e_busy(), e_ready(), 2'(sent)});
      end
      step();
    end
    rst = 1'b1;
    din_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; din_valid = 1'b0; din = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
